// File: rtl/lsu_misc_rd_pkg.sv
// Shared types and constants for the LSU misc-read return sequencer.
package lsu_misc_rd_pkg;

  typedef logic [1:0] tid_t;
  typedef logic [1:0] way_t;
  typedef logic [1:0] src_t;

  localparam src_t SRC_LDXA   = 2'd0;
  localparam src_t SRC_TLBRD  = 2'd1;
  localparam src_t SRC_WTCHPT = 2'd2;
  localparam src_t SRC_DTAG   = 2'd3;

  typedef struct packed {
    logic vld;
    tid_t tid;
    src_t src;
    way_t way;
  } pipe_ent_t;

  function automatic logic [3:0] onehot4(input logic [1:0] v);
    return 4'b0001 << v;
  endfunction

endpackage

// File: rtl/lsu_misc_rd_rrarb.sv
// Round-robin arbiter over NTHR requesters; the pointer moves past the winner
// and stays put on cycles without a grant.
module lsu_misc_rd_rrarb
  import lsu_misc_rd_pkg::*;
#(
  parameter int NTHR = 4
) (
  input  logic            rclk,
  input  logic            arst_l,
  input  logic            en,
  input  logic [NTHR-1:0] req,
  output logic [NTHR-1:0] gnt,
  output tid_t            gnt_tid,
  output logic            gnt_vld
);

  tid_t ptr_q, ptr_d;

  // Scan from the farthest offset down so the requester closest to ptr wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_tid = '0;
    gnt_vld = 1'b0;
    for (int i = NTHR - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % NTHR;
      if (en && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_tid = tid_t'(idx);
      end
    end
    if (gnt_vld) gnt[gnt_tid] = 1'b1;
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = tid_t'((int'(gnt_tid) + 1) % NTHR);
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/lsu_misc_rd_ctl.sv
// Misc-read return sequencer: credit-gated arbitration, M/G selects and W2 valid.
// Optional diag-tag parity capture is enabled with LSU_MISC_RD_PARITY_EN.
module lsu_misc_rd_ctl
  import lsu_misc_rd_pkg::*;
#(
  parameter int NTHR    = 4,
  parameter int CREDITS = 2
) (
  input  logic            rclk,
  input  logic            arst_l,
  input  logic [NTHR-1:0] rd_req_m,
  input  logic [2*NTHR-1:0] rd_type_m,
  input  logic [2*NTHR-1:0] rd_way_m,
  output logic [NTHR-1:0] rd_gnt_m,
  output logic [3:0]      lsu_dtag_rsel_m,
  output logic            lsu_local_ldxa_sel_g,
  output logic            lsu_local_ldxa_tlbrd_sel_g,
  output logic            lsu_va_wtchpt_sel_g,
  output logic            lsu_local_diagnstc_tagrd_sel_g,
  input  logic [3:0]      lsu_rd_dtag_parity_g,
  output logic            misc_rd_vld_w2,
  output logic [1:0]      misc_rd_tid_w2,
  output logic            misc_rd_perr_w2,
  input  logic            misc_rd_ack
);

  localparam int            CW       = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  logic [CW-1:0] credit_q, credit_d;
  logic          credit_ok;
  logic          gnt_vld;
  tid_t          gnt_tid;
  pipe_ent_t     m_ent;
  pipe_ent_t     g_q, g_d;
  logic [3:0]    g_sel_q, g_sel_d;
  logic          vld_w2_q, vld_w2_d;
  tid_t          tid_w2_q, tid_w2_d;
  logic          perr_w2_q, perr_w2_d;

  // An ack in the same cycle frees the slot the new grant will occupy.
  assign credit_ok = (credit_q != '0) | misc_rd_ack;

  lsu_misc_rd_rrarb #(.NTHR(NTHR)) u_arb (
    .rclk    (rclk),
    .arst_l  (arst_l),
    .en      (credit_ok & arst_l),
    .req     (rd_req_m),
    .gnt     (rd_gnt_m),
    .gnt_tid (gnt_tid),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    m_ent.vld = gnt_vld;
    m_ent.tid = gnt_tid;
    m_ent.src = src_t'(rd_type_m[2*int'(gnt_tid) +: 2]);
    m_ent.way = way_t'(rd_way_m[2*int'(gnt_tid) +: 2]);
    lsu_dtag_rsel_m = 4'b0001;
    if (m_ent.vld && m_ent.src == SRC_DTAG) lsu_dtag_rsel_m = onehot4(m_ent.way);
  end

  always_comb begin
    g_d      = m_ent;
    g_sel_d  = m_ent.vld ? onehot4(m_ent.src) : 4'b0000;
    vld_w2_d = g_q.vld;
    tid_w2_d = g_q.tid;
`ifdef LSU_MISC_RD_PARITY_EN
    perr_w2_d = g_q.vld && (g_q.src == SRC_DTAG) && lsu_rd_dtag_parity_g[g_q.way];
`else
    perr_w2_d = 1'b0;
`endif
  end

`ifndef LSU_MISC_RD_PARITY_EN
  logic unused_par;
  assign unused_par = ^{lsu_rd_dtag_parity_g, g_q.src, g_q.way};
`endif

  // Ack with no grant at full credit is illegal; hold the count rather than wrap.
  always_comb begin
    credit_d = credit_q;
    if (gnt_vld && !misc_rd_ack)
      credit_d = credit_q - CW'(1);
    else if (!gnt_vld && misc_rd_ack && credit_q != CRED_MAX)
      credit_d = credit_q + CW'(1);
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      credit_q  <= CRED_MAX;
      g_q       <= '0;
      g_sel_q   <= '0;
      vld_w2_q  <= 1'b0;
      tid_w2_q  <= '0;
      perr_w2_q <= 1'b0;
    end else begin
      credit_q  <= credit_d;
      g_q       <= g_d;
      g_sel_q   <= g_sel_d;
      vld_w2_q  <= vld_w2_d;
      tid_w2_q  <= tid_w2_d;
      perr_w2_q <= perr_w2_d;
    end
  end

  assign lsu_local_ldxa_sel_g           = g_sel_q[SRC_LDXA];
  assign lsu_local_ldxa_tlbrd_sel_g     = g_sel_q[SRC_TLBRD];
  assign lsu_va_wtchpt_sel_g            = g_sel_q[SRC_WTCHPT];
  assign lsu_local_diagnstc_tagrd_sel_g = g_sel_q[SRC_DTAG];
  assign misc_rd_vld_w2                 = vld_w2_q;
  assign misc_rd_tid_w2                 = tid_w2_q;
  assign misc_rd_perr_w2                = perr_w2_q;

`ifndef SYNTHESIS
  ack_overflow_a: assert property (@(posedge rclk) disable iff (!arst_l)
    !(misc_rd_ack && credit_q == CRED_MAX));
`endif

endmodule

// File: tb/tb_lsu_misc_rd_ctl.sv
// Bench for lsu_misc_rd_ctl: directed vector table, reset/credit sequences and
// a randomized phase checked against a timestamped-queue model.
module tb_lsu_misc_rd_ctl;

  localparam int NTHR    = 4;
  localparam int CREDITS = 2;
`ifdef LSU_MISC_RD_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       rclk = 1'b0;
  logic       arst_l = 1'b0;
  logic [3:0] rd_req_m = '0;
  logic [7:0] rd_type_m = '0;
  logic [7:0] rd_way_m = '0;
  logic [3:0] rd_gnt_m;
  logic [3:0] lsu_dtag_rsel_m;
  logic       sel0, sel1, sel2, sel3;
  logic [3:0] lsu_rd_dtag_parity_g = '0;
  logic       misc_rd_vld_w2;
  logic [1:0] misc_rd_tid_w2;
  logic       misc_rd_perr_w2;
  logic       misc_rd_ack = 1'b0;

  lsu_misc_rd_ctl #(.NTHR(NTHR), .CREDITS(CREDITS)) dut (
    .rclk                           (rclk),
    .arst_l                         (arst_l),
    .rd_req_m                       (rd_req_m),
    .rd_type_m                      (rd_type_m),
    .rd_way_m                       (rd_way_m),
    .rd_gnt_m                       (rd_gnt_m),
    .lsu_dtag_rsel_m                (lsu_dtag_rsel_m),
    .lsu_local_ldxa_sel_g           (sel0),
    .lsu_local_ldxa_tlbrd_sel_g     (sel1),
    .lsu_va_wtchpt_sel_g            (sel2),
    .lsu_local_diagnstc_tagrd_sel_g (sel3),
    .lsu_rd_dtag_parity_g           (lsu_rd_dtag_parity_g),
    .misc_rd_vld_w2                 (misc_rd_vld_w2),
    .misc_rd_tid_w2                 (misc_rd_tid_w2),
    .misc_rd_perr_w2                (misc_rd_perr_w2),
    .misc_rd_ack                    (misc_rd_ack)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  // Reference model: each granted read is a record stamped with its grant cycle;
  // it is at G one cycle later and at W2 two cycles later.
  typedef struct {
    int gcyc;
    int tid;
    int typ;
    int way;
    int perr;
  } rec_t;
  rec_t pipe_q[$];
  int   m_credit = CREDITS;
  int   m_ptr = 0;
  int   m_cyc = 0;
  int   m_gtid, m_gtyp, m_gway;
  logic [3:0] e_gnt, e_rsel, e_gsel;
  logic e_vld, e_perr;
  logic [1:0] e_tid;

  typedef struct {
    logic [3:0] req;
    logic [7:0] typ;
    logic [7:0] way;
    logic       ack;
    logic [3:0] par;
    logic [3:0] gnt;
    logic [3:0] rsel;
    logic [3:0] gsel;
    logic       vld;
    logic [1:0] tid;
    logic       perr;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, m_cyc, act, exp);
    end
  endtask

  function automatic bit w2_pending();
    foreach (pipe_q[k]) if (pipe_q[k].gcyc == m_cyc - 2) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_eval();
    int t;
    e_gnt = '0; e_rsel = 4'b0001; e_gsel = '0;
    e_vld = 1'b0; e_tid = '0; e_perr = 1'b0;
    m_gtid = -1; m_gtyp = 0; m_gway = 0;
    if (arst_l && (m_credit > 0 || misc_rd_ack)) begin
      for (int i = 0; i < NTHR; i++) begin
        t = (m_ptr + i) % NTHR;
        if (rd_req_m[t]) begin
          m_gtid = t;
          m_gtyp = int'(rd_type_m[2*t +: 2]);
          m_gway = int'(rd_way_m[2*t +: 2]);
          break;
        end
      end
    end
    if (m_gtid >= 0) begin
      e_gnt[m_gtid] = 1'b1;
      if (m_gtyp == 3) e_rsel = 4'b0001 << m_gway;
    end
    foreach (pipe_q[k]) begin
      if (pipe_q[k].gcyc == m_cyc - 1) begin
        e_gsel = 4'b0001 << pipe_q[k].typ;
        if (PAR_EN && pipe_q[k].typ == 3) pipe_q[k].perr = int'(lsu_rd_dtag_parity_g[pipe_q[k].way]);
      end
      if (pipe_q[k].gcyc == m_cyc - 2) begin
        e_vld = 1'b1;
        e_tid = pipe_q[k].tid[1:0];
        e_perr = pipe_q[k].perr[0];
      end
    end
  endtask

  task automatic model_commit();
    if (m_gtid >= 0) begin
      pipe_q.push_back('{m_cyc, m_gtid, m_gtyp, m_gway, 0});
      m_ptr = (m_gtid + 1) % NTHR;
      if (!misc_rd_ack) m_credit--;
    end else if (misc_rd_ack && m_credit < CREDITS) begin
      m_credit++;
    end
    m_cyc++;
    while (pipe_q.size() > 0 && pipe_q[0].gcyc < m_cyc - 2) void'(pipe_q.pop_front());
  endtask

  // Called at posedge+1: drive, settle, evaluate model.
  task automatic apply(input logic [3:0] req, input logic [7:0] typ, input logic [7:0] way,
                       input logic ack, input logic [3:0] par);
    rd_req_m = req; rd_type_m = typ; rd_way_m = way;
    misc_rd_ack = ack; lsu_rd_dtag_parity_g = par;
    #3;
    model_eval();
  endtask

  task automatic check_model();
    chk("gnt", rd_gnt_m, e_gnt);
    chk("rsel", lsu_dtag_rsel_m, e_rsel);
    chk("gsel", {sel3, sel2, sel1, sel0}, e_gsel);
    chk("vld_w2", misc_rd_vld_w2, e_vld);
    if (e_vld) chk("tid_w2", misc_rd_tid_w2, e_tid);
    chk("perr_w2", misc_rd_perr_w2, e_perr);
    if (misc_rd_vld_w2)
      $display("ret cyc=%0d tid=%0d perr=%0d", m_cyc, misc_rd_tid_w2, misc_rd_perr_w2);
  endtask

  task automatic advance();
    @(posedge rclk);
    model_commit();
    #1;
  endtask

  initial begin
    int ngnt, nvld;
    logic [7:0] rtyp, rway;
    logic [3:0] rreq;
    logic       rack;

    tbl = '{
      '{4'b0100, 8'h10, 8'h00, 1'b0, 4'h0, 4'b0100, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b0000, 8'h00, 8'h00, 1'b0, 4'h0, 4'b0000, 4'b0001, 4'b0010, 1'b0, 2'd0, 1'b0},
      '{4'b0000, 8'h00, 8'h00, 1'b1, 4'h0, 4'b0000, 4'b0001, 4'b0000, 1'b1, 2'd2, 1'b0},
      '{4'b0001, 8'h03, 8'h03, 1'b0, 4'h0, 4'b0001, 4'b1000, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b0000, 8'h00, 8'h00, 1'b0, 4'h8, 4'b0000, 4'b0001, 4'b1000, 1'b0, 2'd0, 1'b0},
      '{4'b0000, 8'h00, 8'h00, 1'b1, 4'h0, 4'b0000, 4'b0001, 4'b0000, 1'b1, 2'd0, PAR_EN},
      '{4'b1111, 8'h00, 8'h00, 1'b0, 4'h0, 4'b0010, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b1111, 8'h00, 8'h00, 1'b0, 4'h0, 4'b0100, 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b0},
      '{4'b1111, 8'h00, 8'h00, 1'b0, 4'h0, 4'b0000, 4'b0001, 4'b0001, 1'b1, 2'd1, 1'b0},
      '{4'b1111, 8'h00, 8'h00, 1'b0, 4'h0, 4'b0000, 4'b0001, 4'b0000, 1'b1, 2'd2, 1'b0},
      '{4'b1111, 8'h00, 8'h00, 1'b1, 4'h0, 4'b1000, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b1111, 8'h00, 8'h00, 1'b1, 4'h0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b0},
      '{4'b0000, 8'h00, 8'h00, 1'b0, 4'h0, 4'b0000, 4'b0001, 4'b0001, 1'b1, 2'd3, 1'b0},
      '{4'b0000, 8'h00, 8'h00, 1'b1, 4'h0, 4'b0000, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b0},
      '{4'b0010, 8'h00, 8'h00, 1'b1, 4'h0, 4'b0010, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b0100, 8'h00, 8'h00, 1'b0, 4'h0, 4'b0100, 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b0},
      '{4'b0000, 8'h00, 8'h00, 1'b1, 4'h0, 4'b0000, 4'b0001, 4'b0001, 1'b1, 2'd1, 1'b0},
      '{4'b0000, 8'h00, 8'h00, 1'b1, 4'h0, 4'b0000, 4'b0001, 4'b0000, 1'b1, 2'd2, 1'b0},
      '{4'b0000, 8'h00, 8'h00, 1'b0, 4'h0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0}
    };

    // Reset state
    #12;
    chk("rst_gnt", rd_gnt_m, 8'h0);
    chk("rst_rsel", lsu_dtag_rsel_m, 8'h1);
    chk("rst_gsel", {sel3, sel2, sel1, sel0}, 8'h0);
    chk("rst_w2", {misc_rd_perr_w2, misc_rd_tid_w2, misc_rd_vld_w2}, 8'h0);
    @(posedge rclk); #1;
    arst_l = 1'b1;

    // Directed vector table
    for (int r = 0; r < 19; r++) begin
      apply(tbl[r].req, tbl[r].typ, tbl[r].way, tbl[r].ack, tbl[r].par);
      chk("tbl_gnt", rd_gnt_m, tbl[r].gnt);
      chk("tbl_rsel", lsu_dtag_rsel_m, tbl[r].rsel);
      chk("tbl_gsel", {sel3, sel2, sel1, sel0}, tbl[r].gsel);
      chk("tbl_vld", misc_rd_vld_w2, tbl[r].vld);
      if (tbl[r].vld) chk("tbl_tid", misc_rd_tid_w2, tbl[r].tid);
      chk("tbl_perr", misc_rd_perr_w2, tbl[r].perr);
      check_model();
      advance();
    end

    // Streaming: all threads request, each W2 return acked in the same cycle
    ngnt = 0; nvld = 0;
    for (int c = 0; c < 16; c++) begin
      apply(4'b1111, 8'h00, 8'h00, w2_pending(), 4'h0);
      check_model();
      ngnt += $countones(rd_gnt_m);
      if (c >= 2) nvld += int'(misc_rd_vld_w2);
      advance();
    end
    chk("stream_gnts", 8'(ngnt), 8'd16);
    chk("stream_vlds", 8'(nvld), 8'd14);
    for (int c = 0; c < 2; c++) begin
      apply(4'b0000, 8'h00, 8'h00, w2_pending(), 4'h0);
      check_model();
      advance();
    end

    // Randomized phase
    for (int c = 0; c < 300; c++) begin
      rreq = 4'($urandom);
      rtyp = 8'($urandom);
      rway = 8'($urandom);
      rack = (m_credit < CREDITS) ? 1'($urandom) : 1'b0;
      apply(rreq, rtyp, rway, rack, 4'($urandom));
      check_model();
      advance();
    end

    // Reset the cycle after a grant: nothing may emerge at W2
    apply(4'b0010, 8'h08, 8'h00, (m_credit == 0) ? 1'b1 : 1'b0, 4'h0);
    chk("prerst_gnt", rd_gnt_m, 8'b0010);
    check_model();
    advance();
    arst_l = 1'b0;
    rd_req_m = '0; misc_rd_ack = 1'b0;
    #2;
    chk("midrst_gsel", {sel3, sel2, sel1, sel0}, 8'h0);
    chk("midrst_rsel", lsu_dtag_rsel_m, 8'h1);
    chk("midrst_vld", misc_rd_vld_w2, 8'h0);
    pipe_q.delete();
    m_credit = CREDITS;
    m_ptr = 0;
    @(posedge rclk); @(posedge rclk); #1;
    arst_l = 1'b1;
    for (int c = 0; c < 4; c++) begin
      apply(4'b0000, 8'h00, 8'h00, 1'b0, 4'h0);
      chk("postrst_vld", misc_rd_vld_w2, 8'h0);
      check_model();
      advance();
    end
    // Credit must be back to CREDITS: exactly that many grants with no ack
    ngnt = 0;
    for (int c = 0; c < 4; c++) begin
      apply(4'b1111, 8'h00, 8'h00, 1'b0, 4'h0);
      check_model();
      ngnt += $countones(rd_gnt_m);
      advance();
    end
    chk("postrst_credit", 8'(ngnt), 8'(CREDITS));
    for (int c = 0; c < 2; c++) begin
      apply(4'b0000, 8'h00, 8'h00, 1'b1, 4'h0);
      check_model();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_misc_rd_ctl.md
Name: lsu_misc_rd_ctl

Overview:
- Sequencer/arbiter for the LSU misc-read return datapath: the 4-way dtag select, the G-stage misc-rdata mux and the W2 flop.
- Arbitrates per-thread ASI read requests: local ldxa, TLB read, VA watchpoint read and diagnostic dtag read.
- Drives the one-hot M-stage way select and the one-hot G-stage source select.
- Tracks each granted read through M -> G -> W2 and presents valid plus thread id alongside the W2 data to qdp1.
- Issues a grant only when return credit exists, because the datapath flops have no enable.

Parameters:
NTHR, 4, number of requesting threads (thread id width 2).
CREDITS, 2, return-buffer entries in qdp1; max outstanding unacknowledged W2 returns.

Ports:
rclk  in  1  core clock
arst_l  in  1  asynchronous active-low reset
rd_req_m  in  NTHR  per-thread read request, level, held until granted
rd_type_m  in  2*NTHR  per-thread source: 0 ldxa, 1 tlbrd, 2 wtchpt, 3 diag tag
rd_way_m  in  2*NTHR  per-thread dtag way for diag tag read
rd_gnt_m  out  NTHR  one-hot grant, same cycle as request (combinational from state)
lsu_dtag_rsel_m  out  4  one-hot way select to the dtag mux; 0001 when idle
lsu_local_ldxa_sel_g  out  1  G source select 0
lsu_local_ldxa_tlbrd_sel_g  out  1  G source select 1
lsu_va_wtchpt_sel_g  out  1  G source select 2
lsu_local_diagnstc_tagrd_sel_g  out  1  G source select 3
lsu_rd_dtag_parity_g  in  4  per-way parity result (used only with option)
misc_rd_vld_w2  out  1  W2 data valid
misc_rd_tid_w2  out  2  thread id of W2 data
misc_rd_perr_w2  out  1  diag tag parity error flag
misc_rd_ack  in  1  qdp1 frees one return-buffer entry

Behaviour:
- Reset (arst_l low, async):
  - all grants 0; lsu_dtag_rsel_m=0001; all four G selects 0; vld/tid/perr_w2=0.
  - credit counter=CREDITS; round-robin pointer=0.
- Arbitration:
  - Round-robin over rd_req_m, starting at pointer.
  - Grant only if credit>0, or if credit==0 and misc_rd_ack is high the same cycle (ack-bypass).
  - At most one grant per cycle.
  - After a grant, pointer = granted tid+1 mod NTHR; no grant, pointer unchanged.
- M stage (grant cycle):
  - If the granted type is 3, lsu_dtag_rsel_m = decode(rd_way_m of the granted thread); otherwise 0001.
  - The select is always one-hot, as required by mux4ds.
- G stage (+1):
  - Exactly one of the four G selects is high, per the registered type.
  - When the G stage is empty, all four are 0. mux4ds output is then don't-care and is not qualified downstream.
- W2 (+2): misc_rd_vld_w2=1 with registered tid; latency from grant to vld_w2 is exactly 2 cycles.
- Pipeline: fully pipelined; back-to-back grants allowed every cycle while credits last.
- Credits:
  - grant without ack: -1; ack without grant: +1; both: unchanged.
  - Ack while credit==CREDITS is a protocol error: counter saturates, and an assertion fires in simulation.
- Reset mid-operation: in-flight M/G entries are discarded and no W2 valid is produced; credit returns to CREDITS.
- Requesters never see a grant for a deasserted request; a request dropped before grant is legal.

Optional Feature:
LSU_MISC_RD_PARITY_EN
- Defined:
  - At G, for a type-3 read, capture lsu_rd_dtag_parity_g[way] of the registered way (nonzero means error).
  - Register it to misc_rd_perr_w2, aligned with misc_rd_vld_w2.
  - Non-diag reads give perr=0.
- Undefined: misc_rd_perr_w2 is tied 0; lsu_rd_dtag_parity_g is unused.

Decomposition:
- Shared package lsu_misc_rd_pkg:
  - source-type constants SRC_LDXA=0, SRC_TLBRD=1, SRC_WTCHPT=2, SRC_DTAG=3.
  - 2-bit tid/way typedefs.
  - pipe-entry struct {vld, tid, type, way}.
- One natural sub-module, lsu_misc_rd_rrarb: NTHR-wide round-robin arbiter with enable (credit_ok); returns a one-hot grant and the encoded tid.
- Pipe registers and the credit counter stay in the top.

Test Plan:
- Single request, tid2 type1 (tlbrd), credit 2 -> rd_gnt_m=0100 same cycle; next cycle only lsu_local_ldxa_tlbrd_sel_g=1; then vld_w2=1, tid_w2=2.
- Diag tag read, tid0 way3 -> lsu_dtag_rsel_m=1000 in grant cycle; G-stage tagrd sel=1 next cycle; W2 valid cycle after. With the option and parity_g=1000 at G -> perr_w2=1.
- All four threads request continuously, CREDITS=4, ack each return -> grants tid 0,1,2,3,0… one per cycle; vld_w2 every cycle.
- CREDITS=2, no ack -> two grants, then no grant while requests are held. Ack pulse -> one further grant the same cycle via bypass.
- Assert arst_l low the cycle after a grant -> no vld_w2 ever produced; selects 0, rsel=0001, credit=CREDITS after release.
- Simultaneous grant and ack at credit 1 -> credit stays 1; next request is granted.
